ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//  Execute->memory boundary stage. Captures the ALU result and flags, resolves branches/jumps,
//  and emits a one-cycle PC redirect when a branch or jump is taken (fetch predicts not-taken).
//  Holds a 2-entry elastic buffer (main + skid) toward the memory stage using valid/ready.
//  Sits directly downstream of alu, upstream of the data-memory stage.
// PARAMETERS
//  REG_WIDTH  32  datapath / PC width
//  RADDR_W    5   register-file address width
// PORTS
//  clk               in   1          clock, all state updates on rising edge
//  rst_n             in   1          synchronous reset, active low
//  i_valid           in   1          upstream entry valid
//  o_ready           out  1          stage can accept; = (state != FULL)
//  i_result          in   REG_WIDTH  ALU o_result
//  i_zero            in   1          ALU o_zero
//  i_less_than       in   1          ALU o_less_than (signedness chosen by ALU control)
//  i_pc              in   REG_WIDTH  PC of the instruction
//  i_imm             in   REG_WIDTH  sign-extended immediate
//  i_store_data      in   REG_WIDTH  rs2 value for stores
//  i_branch          in   3          branch_t: BR_NONE/EQ/NE/LT/GE/JAL/JALR
//  i_rd              in   RADDR_W    destination register
//  i_reg_write       in   1          writeback enable
//  i_mem_read        in   1          load
//  i_mem_write       in   1          store
//  i_flush           in   1          kill all held entries and the current input
//  o_valid           out  1          head entry valid toward memory stage
//  i_ready           in   1          memory stage accepts head
//  o_result/o_store_data  out  REG_WIDTH  head payload
//  o_rd              out  RADDR_W    head payload
//  o_reg_write/o_mem_read/o_mem_write  out  1  head payload
//  o_redirect_valid  out  1          one-cycle pulse: fetch must jump
//  o_redirect_pc     out  REG_WIDTH  redirect target, valid with pulse
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=EMPTY; o_valid=0, o_redirect_valid=0, every payload output and
//   o_redirect_pc=0; o_ready=1 combinationally from state. Reset mid-transfer discards all entries.
//  accept = i_valid & o_ready & ~i_flush;  pop = o_valid & i_ready.
//  States: EMPTY -accept-> ONE; ONE -accept&~pop-> FULL; ONE -pop&~accept-> EMPTY;
//   ONE -accept&pop-> ONE (main reloads); FULL -pop-> ONE (skid moves to main); FULL never accepts.
//  i_flush: next state EMPTY from any state, o_valid=0 next cycle; input that cycle is dropped;
//   no redirect for it. A redirect already pulsing is not retracted.
//  Latency: accepted entry appears at o_valid the next cycle (EMPTY case); FIFO order always.
//  Payload outputs are driven from the main register only; hold stable while o_valid & ~i_ready.
//  Branch resolution at accept (combinational on inputs, registered to outputs):
//   EQ taken=i_zero; NE=~i_zero; LT=i_less_than; GE=~i_less_than; JAL/JALR always; NONE never.
//   Branch target = i_pc + i_imm (local adder, mod 2^REG_WIDTH, wraps silently).
//   JAL/JALR target = {i_result[REG_WIDTH-1:1],1'b0} (ALU computed pc+imm / rs1+imm).
//   JAL/JALR stored o_result = i_pc + 4 (link value); other types store i_result unchanged.
//   Conditional branches stored with reg_write/mem_read/mem_write forced 0.
//  o_redirect_valid=1 exactly in the cycle after an accept with taken=1; 0 otherwise.
//   Redirect never waits on i_ready (entry may be held while pulse fires).
//  Younger-instruction squash after a redirect is upstream control's job via i_flush.
// STRUCTURE
//  ex_pkg: branch_t enum, ex_state_t {EMPTY,ONE,FULL}, ex_mem_t packed payload struct.
//  Sub-module: pipe_skid_buf #(type T) holds main/skid registers + state; this module adds
//   branch resolution, link/target math, and the redirect register.
// TESTING
//  BEQ pc=0x100 imm=0x20 zero=1 i_ready=1 -> next cycle redirect pulse pc=0x120, o_valid,
//   o_reg_write=0; repeat with zero=0 -> no pulse.
//  JALR i_result=0x1235 pc=0x40 rd=1 -> redirect_pc=0x1234, o_result=0x44, o_reg_write=1.
//  i_ready=0, 3 back-to-back valids A,B,C -> A,B accepted, o_ready=0, C held; raise i_ready ->
//   A,B,C emerge in order, no duplicates.
//  FULL state, i_flush=1 with i_valid=1 and taken BNE -> next cycle o_valid=0, o_ready=1, no pulse.
//  ONE state with i_valid & i_ready both 1 for 4 cycles -> 1 entry/cycle throughput, state ONE.
//  rst_n=0 while FULL with pulse pending -> next cycle all outputs 0, o_ready=1.

Source files
------------

// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_pkg
//  Purpose  : Shared types for the execute->memory boundary: branch type
//             encoding, elastic-buffer occupancy state and the payload
//             carried toward the data-memory stage.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ex_pkg;

  localparam int EX_XLEN    = 32;
  localparam int EX_RADDR_W = 5;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_JAL  = 3'd5,
    BR_JALR = 3'd6
  } branch_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ex_state_t;

  typedef struct packed {
    logic [EX_XLEN-1:0]    result;
    logic [EX_XLEN-1:0]    store_data;
    logic [EX_RADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } ex_mem_t;

  // Conditional branches compare flags; jumps are unconditional.
  function automatic logic is_cond_branch(input branch_t b);
    return (b == BR_EQ) || (b == BR_NE) || (b == BR_LT) || (b == BR_GE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_buf
//  Purpose  : Two-entry elastic buffer (main + skid) with valid/ready on both
//             sides. Output payload always comes from the main register so
//             it stays stable while the consumer stalls.
//  Ports    : clk, rst_n (sync, active low), i_flush (drop everything),
//             i_valid/o_ready/i_data upstream, o_valid/i_ready/o_data
//             downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_buf
  import ex_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  ex_state_t state_q, state_d;
  T          main_q, main_d;
  T          skid_q, skid_d;
  logic      accept, pop;

  assign o_ready = (state_q != FULL);
  assign o_valid = (state_q != EMPTY);
  assign o_data  = main_q;
  assign accept  = i_valid & o_ready & ~i_flush;
  assign pop     = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = i_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = i_data;
        end else if (accept) begin
          skid_d  = i_data;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Full never accepts, even on a pop; the skid entry moves up.
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (i_flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_stage
//  Purpose  : Execute->memory boundary. Resolves branches/jumps on the entry
//             being accepted, stores link value or ALU result into a 2-entry
//             elastic buffer, and pulses a PC redirect the cycle after a
//             taken branch/jump is accepted (fetch predicts not-taken).
//  Ports    : clk, rst_n (sync, active low)
//             i_valid/o_ready, ALU result+flags, pc, imm, store data,
//             branch type, rd, reg_write/mem_read/mem_write, i_flush
//             o_valid/i_ready + head payload toward memory stage
//             o_redirect_valid/o_redirect_pc toward fetch
//  Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int REG_WIDTH = EX_XLEN,
  parameter int RADDR_W   = EX_RADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [REG_WIDTH-1:0] i_result,
  input  logic                 i_zero,
  input  logic                 i_less_than,
  input  logic [REG_WIDTH-1:0] i_pc,
  input  logic [REG_WIDTH-1:0] i_imm,
  input  logic [REG_WIDTH-1:0] i_store_data,
  input  logic [2:0]           i_branch,
  input  logic [RADDR_W-1:0]   i_rd,
  input  logic                 i_reg_write,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [REG_WIDTH-1:0] o_result,
  output logic [REG_WIDTH-1:0] o_store_data,
  output logic [RADDR_W-1:0]   o_rd,
  output logic                 o_reg_write,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_redirect_valid,
  output logic [REG_WIDTH-1:0] o_redirect_pc
);

  branch_t              br;
  logic                 taken;
  logic                 accept;
  logic [REG_WIDTH-1:0] target;
  ex_mem_t              entry;
  ex_mem_t              head;

  logic                 redirect_valid_q, redirect_valid_d;
  logic [REG_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  always_comb begin
    br               = branch_t'(i_branch);
    taken            = 1'b0;
    target           = i_pc + i_imm;  // wraps mod 2^REG_WIDTH
    entry.result     = i_result;
    entry.store_data = i_store_data;
    entry.rd         = i_rd;
    entry.reg_write  = i_reg_write;
    entry.mem_read   = i_mem_read;
    entry.mem_write  = i_mem_write;
    case (br)
      BR_EQ:   taken = i_zero;
      BR_NE:   taken = ~i_zero;
      BR_LT:   taken = i_less_than;
      BR_GE:   taken = ~i_less_than;
      BR_JAL, BR_JALR: begin
        // ALU already produced the jump address; clear bit 0 and keep the
        // link value as the writeback result.
        taken        = 1'b1;
        target       = {i_result[REG_WIDTH-1:1], 1'b0};
        entry.result = i_pc + REG_WIDTH'(4);
      end
      default: taken = 1'b0;
    endcase
    if (is_cond_branch(br)) begin
      entry.reg_write = 1'b0;
      entry.mem_read  = 1'b0;
      entry.mem_write = 1'b0;
    end
  end

  assign accept = i_valid & o_ready & ~i_flush;

  // Redirect is independent of downstream backpressure; a pulse already on
  // the output is not cancelled by a flush.
  always_comb begin
    redirect_valid_d = accept & taken;
    redirect_pc_d    = redirect_pc_q;
    if (accept && taken) begin
      redirect_pc_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  pipe_skid_buf #(
    .T (ex_mem_t)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (entry),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (head)
  );

  assign o_result         = head.result;
  assign o_store_data     = head.store_data;
  assign o_rd             = head.rd;
  assign o_reg_write      = head.reg_write;
  assign o_mem_read       = head.mem_read;
  assign o_mem_write      = head.mem_write;
  assign o_redirect_valid = redirect_valid_q;
  assign o_redirect_pc    = redirect_pc_q;

endmodule
`default_nettype wire
